// File: rtl/crop_bbox_detect.sv
// Streaming bounding-box detector: tracks the min/max X/Y of threshold-qualified pixels inside
// a fixed ROI and publishes a registered box plus a found flag once per frame.
module crop_bbox_detect #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned DW       = 10,
  parameter int unsigned CW       = 16,
  parameter int unsigned ROI_X0   = 161,
  parameter int unsigned ROI_X1   = 479,
  parameter int unsigned ROI_Y0   = 11,
  parameter int unsigned ROI_Y1   = 469,
  parameter bit          POLARITY = 1'b0
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iDVAL,
  input  logic [DW-1:0] iDATA,
  input  logic [DW-1:0] iTHRESH,
  input  logic          iMODE,
  input  logic          iCLR,
  output logic          oDVAL,
  output logic [CW-1:0] oXSTART,
  output logic [CW-1:0] oXEND,
  output logic [CW-1:0] oYSTART,
  output logic [CW-1:0] oYEND,
  output logic          oFOUND,
  output logic          oFRAME_DONE
);

  localparam logic [CW-1:0] XLast = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] YLast = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] RoiX0 = CW'(ROI_X0);
  localparam logic [CW-1:0] RoiX1 = CW'(ROI_X1);
  localparam logic [CW-1:0] RoiY0 = CW'(ROI_Y0);
  localparam logic [CW-1:0] RoiY1 = CW'(ROI_Y1);

  typedef enum logic [0:0] {StRun, StPublish} state_e;

  state_e state_q, state_d;

  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [CW-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic          hit_q, hit_d;

  logic [CW-1:0] xstart_q, xstart_d, xend_q, xend_d;
  logic [CW-1:0] ystart_q, ystart_d, yend_q, yend_d;
  logic          found_q, found_d;
  logic          dval_q;

  logic          in_roi, pol_hit, qualify, last_px;
  logic [CW-1:0] f_min_x, f_max_x, f_min_y, f_max_y;
  logic          f_hit;

  always_comb begin
    in_roi  = (x_q >= RoiX0) && (x_q <= RoiX1) && (y_q >= RoiY0) && (y_q <= RoiY1);
    pol_hit = POLARITY ? (iDATA >= iTHRESH) : (iDATA <= iTHRESH);
    qualify = iDVAL && in_roi && pol_hit;
    last_px = iDVAL && (x_q == XLast) && (y_q == YLast);

    // Scratch box with the current pixel folded in, so the last pixel counts toward its frame.
    f_min_x = min_x_q;
    f_max_x = max_x_q;
    f_min_y = min_y_q;
    f_max_y = max_y_q;
    f_hit   = hit_q;
    if (qualify) begin
      if (x_q < min_x_q) f_min_x = x_q;
      if (x_q > max_x_q) f_max_x = x_q;
      if (y_q < min_y_q) f_min_y = y_q;
      if (y_q > max_y_q) f_max_y = y_q;
      f_hit = 1'b1;
    end
  end

  always_comb begin
    state_d  = StRun;
    x_d      = x_q;
    y_d      = y_q;
    min_x_d  = f_min_x;
    max_x_d  = f_max_x;
    min_y_d  = f_min_y;
    max_y_d  = f_max_y;
    hit_d    = f_hit;
    xstart_d = xstart_q;
    xend_d   = xend_q;
    ystart_d = ystart_q;
    yend_d   = yend_q;
    found_d  = found_q;

    if (iDVAL) begin
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
    end

    if (iCLR) begin
      x_d     = '0;
      y_d     = '0;
      min_x_d = '1;
      max_x_d = '0;
      min_y_d = '1;
      max_y_d = '0;
      hit_d   = 1'b0;
    end else if (last_px) begin
      state_d = StPublish;
      found_d = f_hit;
      if (f_hit) begin
        xstart_d = f_min_x;
        xend_d   = f_max_x;
        ystart_d = f_min_y;
        yend_d   = f_max_y;
      end
      // Per-frame mode restarts the scratch box; accumulate mode lets it keep growing.
      if (!iMODE) begin
        min_x_d = '1;
        max_x_d = '0;
        min_y_d = '1;
        max_y_d = '0;
        hit_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q  <= StRun;
      x_q      <= '0;
      y_q      <= '0;
      min_x_q  <= '1;
      max_x_q  <= '0;
      min_y_q  <= '1;
      max_y_q  <= '0;
      hit_q    <= 1'b0;
      xstart_q <= '0;
      xend_q   <= '0;
      ystart_q <= '0;
      yend_q   <= '0;
      found_q  <= 1'b0;
      dval_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      min_x_q  <= min_x_d;
      max_x_q  <= max_x_d;
      min_y_q  <= min_y_d;
      max_y_q  <= max_y_d;
      hit_q    <= hit_d;
      xstart_q <= xstart_d;
      xend_q   <= xend_d;
      ystart_q <= ystart_d;
      yend_q   <= yend_d;
      found_q  <= found_d;
      dval_q   <= iDVAL;
    end
  end

  assign oDVAL       = dval_q;
  assign oXSTART     = xstart_q;
  assign oXEND       = xend_q;
  assign oYSTART     = ystart_q;
  assign oYEND       = yend_q;
  assign oFOUND      = found_q;
  assign oFRAME_DONE = (state_q == StPublish);

endmodule

// File: tb/tb_crop_bbox_detect.sv
// Directed bench for crop_bbox_detect on an 8x6 raster with ROI 1..6 x 1..4, dark-object polarity.
module tb_crop_bbox_detect;

  localparam int unsigned DW = 10;
  localparam int unsigned CW = 16;
  localparam int NPIX = 48;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b0;
  logic          iDVAL = 1'b0;
  logic [DW-1:0] iDATA = 10'd1023;
  logic [DW-1:0] iTHRESH = '0;
  logic          iMODE = 1'b0;
  logic          iCLR = 1'b0;
  logic          oDVAL;
  logic [CW-1:0] oXSTART, oXEND, oYSTART, oYEND;
  logic          oFOUND, oFRAME_DONE;

  int checks = 0;
  int failures = 0;

  crop_bbox_detect #(
    .H_ACTIVE(8), .V_ACTIVE(6), .DW(DW), .CW(CW),
    .ROI_X0(1), .ROI_X1(6), .ROI_Y0(1), .ROI_Y1(4), .POLARITY(1'b0)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iDATA(iDATA), .iTHRESH(iTHRESH),
    .iMODE(iMODE), .iCLR(iCLR), .oDVAL(oDVAL), .oXSTART(oXSTART), .oXEND(oXEND),
    .oYSTART(oYSTART), .oYEND(oYEND), .oFOUND(oFOUND), .oFRAME_DONE(oFRAME_DONE)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [NPIX-1:0] px(input int x, input int y);
    logic [NPIX-1:0] one;
    one = 1;
    return one << (y * 8 + x);
  endfunction

  // Sends pixels [first, last) of a frame; dark pixels are 0, others 1023.
  task automatic send_pixels(input logic [NPIX-1:0] dark, input int first, input int last,
                             input bit gaps, output int early_done, output int dval_err);
    int idx;
    logic prev;
    idx = first;
    early_done = 0;
    dval_err = 0;
    while (idx < last) begin
      if (gaps && ($urandom_range(1, 0) == 1)) begin
        iDVAL = 1'b0;
        iDATA = 10'd1023;
      end else begin
        iDVAL = 1'b1;
        iDATA = dark[idx] ? 10'd0 : 10'd1023;
        idx++;
      end
      prev = iDVAL;
      @(posedge iCLK); #1;
      if (oDVAL !== prev) dval_err++;
      if (idx < NPIX && oFRAME_DONE === 1'b1) early_done++;
    end
    iDVAL = 1'b0;
    iDATA = 10'd1023;
  endtask

  // Full frame; done_ok requires a pulse right after the last pixel and nothing the cycle after.
  task automatic send_frame(input logic [NPIX-1:0] dark, input bit gaps, output int early_done,
                            output bit done_ok, output int dval_err);
    send_pixels(dark, 0, NPIX, gaps, early_done, dval_err);
    done_ok = (oFRAME_DONE === 1'b1);
    @(posedge iCLK); #1;
    if (oFRAME_DONE !== 1'b0) done_ok = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b0;
    iDVAL = 1'b1;
    repeat (3) @(posedge iCLK);
    #1;
    checks++; if (oDVAL !== 1'b0) begin failures++; $display("FAIL reset_dval got=%0b exp=0", oDVAL); end
    checks++; if ({oXSTART, oXEND, oYSTART, oYEND} !== '0) begin
      failures++; $display("FAIL reset_box got=%0d,%0d,%0d,%0d exp=0,0,0,0", oXSTART, oXEND, oYSTART, oYEND);
    end
    checks++; if (oFOUND !== 1'b0) begin failures++; $display("FAIL reset_found got=%0b exp=0", oFOUND); end
    checks++; if (oFRAME_DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", oFRAME_DONE); end
    iDVAL = 1'b0;
    @(posedge iCLK); #1;
    iRST = 1'b1;
    @(posedge iCLK); #1;
  endtask

  task automatic check_box(input string name, input int xs, input int xe, input int ys,
                           input int ye, input logic fnd, input int early, input bit done_ok);
    checks++; if (early !== 0) begin failures++; $display("FAIL %s_early_done got=%0d exp=0", name, early); end
    checks++; if (!done_ok) begin failures++; $display("FAIL %s_done_pulse got=0 exp=1", name); end
    checks++; if (oXSTART !== CW'(xs) || oXEND !== CW'(xe) || oYSTART !== CW'(ys) || oYEND !== CW'(ye)) begin
      failures++;
      $display("FAIL %s_box got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d", name, oXSTART, oXEND,
               oYSTART, oYEND, xs, xe, ys, ye);
    end
    checks++; if (oFOUND !== fnd) begin failures++; $display("FAIL %s_found got=%0b exp=%0b", name, oFOUND, fnd); end
  endtask

  task automatic test_single();
    int early, derr; bit ok;
    send_frame(px(3, 2), 1'b0, early, ok, derr);
    check_box("single", 3, 3, 2, 2, 1'b1, early, ok);
  endtask

  task automatic test_roi();
    int early, derr; bit ok;
    send_frame(px(0, 0) | px(7, 5) | px(2, 1) | px(6, 4), 1'b0, early, ok, derr);
    check_box("roi", 2, 6, 1, 4, 1'b1, early, ok);
  endtask

  task automatic test_gaps();
    int early, derr; bit ok;
    send_frame(px(0, 0) | px(7, 5) | px(2, 1) | px(6, 4), 1'b1, early, ok, derr);
    check_box("gaps", 2, 6, 1, 4, 1'b1, early, ok);
    checks++; if (derr !== 0) begin failures++; $display("FAIL gaps_dval_delay got_errs=%0d exp=0", derr); end
  endtask

  task automatic test_empty();
    int early, derr; bit ok;
    send_frame('0, 1'b0, early, ok, derr);
    check_box("empty", 2, 6, 1, 4, 1'b0, early, ok);
  endtask

  task automatic test_accum();
    int early, derr; bit ok;
    iMODE = 1'b1;
    send_frame(px(2, 2), 1'b0, early, ok, derr);
    check_box("accum_a", 2, 2, 2, 2, 1'b1, early, ok);
    send_frame(px(5, 4), 1'b0, early, ok, derr);
    check_box("accum_b", 2, 5, 2, 4, 1'b1, early, ok);
    iCLR = 1'b1;
    @(posedge iCLK); #1;
    iCLR = 1'b0;
    iMODE = 1'b0;
    checks++; if (oFRAME_DONE !== 1'b0) begin failures++; $display("FAIL clr_no_done got=1 exp=0"); end
    send_frame('0, 1'b0, early, ok, derr);
    check_box("accum_clr", 2, 5, 2, 4, 1'b0, early, ok);
  endtask

  task automatic test_clr_last();
    int early, derr; bit ok;
    send_pixels(px(2, 2), 0, NPIX - 1, 1'b0, early, derr);
    iDVAL = 1'b1;
    iDATA = 10'd1023;
    iCLR = 1'b1;
    @(posedge iCLK); #1;
    iDVAL = 1'b0;
    iCLR = 1'b0;
    checks++; if (oFRAME_DONE !== 1'b0) begin failures++; $display("FAIL clr_last_done got=1 exp=0"); end
    checks++; if (oXSTART !== CW'(2) || oXEND !== CW'(5) || oFOUND !== 1'b0) begin
      failures++; $display("FAIL clr_last_hold got=%0d,%0d,%0b exp=2,5,0", oXSTART, oXEND, oFOUND);
    end
    @(posedge iCLK); #1;
    send_frame(px(3, 3), 1'b0, early, ok, derr);
    check_box("after_clr", 3, 3, 3, 3, 1'b1, early, ok);
  endtask

  task automatic test_rst_mid();
    int early, derr; bit ok;
    send_pixels(px(1, 1), 0, 20, 1'b0, early, derr);
    iRST = 1'b0;
    #1;
    checks++; if (oXSTART !== '0 || oFOUND !== 1'b0 || oDVAL !== 1'b0) begin
      failures++; $display("FAIL rst_mid_outputs got=%0d,%0b,%0b exp=0,0,0", oXSTART, oFOUND, oDVAL);
    end
    @(posedge iCLK); #1;
    iRST = 1'b1;
    @(posedge iCLK); #1;
    send_frame(px(4, 3), 1'b0, early, ok, derr);
    check_box("rst_mid", 4, 4, 3, 3, 1'b1, early, ok);
  endtask

  initial begin
    test_reset();
    test_single();
    test_roi();
    test_gaps();
    test_empty();
    test_accum();
    test_clr_last();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
